multiplicador_seq: RTL and testbench

MULTIPLICADOR_SEQ -- requirements
Module: multiplicador_seq

---
 rtl/mult_pkg.sv | 13 +
 rtl/somador_mult.sv | 13 +
 rtl/multiplicador_seq.sv | 99 +++++++++
 tb/tb_multiplicador_seq.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier:
// FSM state encoding and the default operand width.
package mult_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/somador_mult.sv
// Unsigned DATA_W-bit adder used by the multiplier accumulator; the carry-out
// is dropped because the product of two unsigned operands always fits.
module somador_mult #(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/multiplicador_seq.sv
// Sequential unsigned shift-and-add multiplier (IDLE -> RUN -> DONE).
// Optional build macro MULT_EARLY_EXIT_EN ends RUN once no multiplier bits remain.
module multiplicador_seq
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   P
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  state_t          state;
  logic [PW-1:0]   mc;
  logic [PW-1:0]   acc;
  logic [PW-1:0]   addend;
  logic [PW-1:0]   acc_next;
  logic [WIDTH-1:0] mr;
  logic [WIDTH-1:0] mr_shift;
  logic [CW-1:0]   cnt;
  logic            run_last;

  // Partial product selected by the current multiplier LSB.
  assign addend   = mr[0] ? mc : '0;
  assign mr_shift = mr >> 1;

  somador_mult #(
    .DATA_W (PW)
  ) u_somador (
    .a   (acc),
    .b   (addend),
    .sum (acc_next)
  );

`ifdef MULT_EARLY_EXIT_EN
  // Once the shifted multiplier is empty no further additions can occur.
  assign run_last = (cnt == LAST_STEP) || (mr_shift == '0);
`else
  assign run_last = (cnt == LAST_STEP);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      mc    <= '0;
      mr    <= '0;
      acc   <= '0;
      cnt   <= '0;
      P     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            mc    <= {{WIDTH{1'b0}}, A};
            mr    <= B;
            acc   <= '0;
            cnt   <= '0;
            state <= RUN;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        RUN: begin
          acc <= acc_next;
          mc  <= mc << 1;
          mr  <= mr_shift;
          cnt <= cnt + 1'b1;
          // The final edge publishes the sum including this step's addition.
          if (run_last) begin
            P     <= acc_next;
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multiplicador_seq.sv
// Scoreboard bench for multiplicador_seq: the driver queues A*B with the
// expected RUN length; a monitor checks every done pulse against the queue.
module tb_multiplicador_seq;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [W-1:0]   A;
  logic [W-1:0]   B;
  logic           busy;
  logic           done;
  logic [2*W-1:0] P;

  typedef struct {
    logic [2*W-1:0] p;
    int             runs;
    int             acc_cyc;
  } exp_t;

  exp_t           q[$];
  int             checks = 0;
  int             failures = 0;
  int             cyc = 0;
  int             busy_run = 0;
  logic [2*W-1:0] last_p = '0;

  multiplicador_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .P     (P)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Number of RUN cycles expected for multiplier value b.
  function automatic int ref_runs(input int b);
`ifdef MULT_EARLY_EXIT_EN
    int hi;
    hi = 0;
    for (int i = 0; i < W; i++)
      if (b[i]) hi = i + 1;
    return (hi == 0) ? 1 : hi;
`else
    return W;
`endif
  endfunction

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: compares each done pulse with the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0) begin
        busy_run = 0;
        continue;
      end
      check("busy_done_exclusive", busy && done, 0);
      if (done) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done actual=1 required=0 (cycle %0d)", cyc);
        end else begin
          e = q.pop_front();
          check("product", P, e.p);
          check("latency", cyc - e.acc_cyc, e.runs);
          check("busy_cycles", busy_run, e.runs);
        end
        last_p   = P;
        busy_run = 0;
      end else begin
        check("p_hold", P, last_p);
        if (busy) busy_run++;
        else busy_run = 0;
      end
    end
  end

  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
    int prod;
    @(negedge clk);
    A = a;
    B = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    prod = int'(a) * int'(b);
    q.push_back('{p: prod[2*W-1:0], runs: ref_runs(int'(b)), acc_cyc: cyc});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 60; i++) begin
      if (q.size() == 0) return;
      @(negedge clk);
      #1;
    end
    checks++;
    failures++;
    $display("FAIL done_timeout actual=%0d pending required=0 pending", q.size());
    q.delete();
  endtask

  initial begin
    int prod;
    int waitn;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    rst = 1'b1;
    start = 1'b0;
    A = '0;
    B = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_P", P, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    last_p = '0;
    @(negedge clk);
    rst = 1'b0;

    // Corner operands.
    launch(8'd255, 8'd255); wait_done();
    launch(8'd0, 8'd200);   wait_done();
    launch(8'd13, 8'd0);    wait_done();
    launch(8'd1, 8'd128);   wait_done();

    // start and operand changes during RUN must be ignored.
    launch(8'd12, 8'd10);
    @(negedge clk);
    A = 8'd99;
    B = 8'd77;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (12) @(negedge clk);

    // start held high through DONE re-enters RUN directly.
    @(negedge clk);
    A = 8'd7;
    B = 8'd9;
    start = 1'b1;
    @(posedge clk);
    #1;
    q.push_back('{p: 16'd63, runs: ref_runs(9), acc_cyc: cyc});
    wait_done();
    @(posedge clk);
    #1;
    q.push_back('{p: 16'd63, runs: ref_runs(9), acc_cyc: cyc});
    check("reentry_busy", busy, 1);
    @(negedge clk);
    start = 1'b0;
    wait_done();

    // Reset in the middle of RUN aborts with no done pulse.
    launch(8'd100, 8'd3);
    waitn = (ref_runs(3) >= 4) ? 3 : 0;
    repeat (waitn) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    q.delete();
    check("abort_P", P, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    last_p = '0;
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    launch(8'd100, 8'd3); wait_done();

    // Randomized operands with random idle gaps.
    for (int n = 0; n < 24; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if ($urandom_range(0, 5) == 0) ra = '0;
      if ($urandom_range(0, 5) == 0) rb = '1;
      if ($urandom_range(0, 7) == 0) rb = '0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      launch(ra, rb);
      wait_done();
    end

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
